// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract accumulator sequencer.
package addsub_pkg;

    // Datapath width; must match the external adder/subtractor.
    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_accumulator_ctrl_flag_gen.sv
// Combinational status-flag generator for the adder/subtractor result.
// V follows the two's-complement overflow rule for the active mode; Z and N
// describe the Sum value that is about to be written to the accumulator.
module accum_flag_gen #(
    parameter int WIDTH = 4
) (
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] sum,
    output logic             v,
    output logic             z,
    output logic             n
);

    logic a_msb;
    logic b_msb;
    logic s_msb;

    assign a_msb = a[WIDTH-1];
    assign b_msb = b[WIDTH-1];
    assign s_msb = sum[WIDTH-1];

    // Overflow: B+A when operand signs agree, B-A when they differ, and the
    // result sign departs from B.
    always_comb begin
        v = 1'b0;
        if (m) v = (a_msb != b_msb) && (s_msb != b_msb);
        else   v = (a_msb == b_msb) && (s_msb != b_msb);
        z = (sum == '0);
        n = s_msb;
    end

endmodule

// File: rtl/addsub_accumulator_ctrl.sv
// Sequencer in front of a combinational 4-bit adder/subtractor. Accepts
// LOAD/ADD/SUB/MUL requests, steers the adder inputs, captures Sum/C4 into an
// accumulator with C/V/Z/N flags and returns the result over valid/ready.
// MUL is repeated addition of acc into a running product, one pass per cycle.
module addsub_accumulator_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = addsub_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             as_M,
    output logic [WIDTH-1:0] as_A,
    output logic [WIDTH-1:0] as_B,
    input  logic [WIDTH-1:0] as_Sum,
    input  logic             as_C4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_c,
    output logic             out_v,
    output logic             out_z,
    output logic             out_n
);

    state_e           state;
    op_e              op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] cnt;
    logic             c_flag;
    logic             v_flag;
    logic             z_flag;
    logic             n_flag;

    logic             fg_v;
    logic             fg_z;
    logic             fg_n;
    op_e              req_op;
    logic             accept;

    assign req_op = op_e'(in_op);
    assign accept = in_valid && in_ready;

    // Adder steering is decoded from registered state only, so it is
    // glitch-free with respect to the request inputs and zero outside EXEC.
    always_comb begin
        as_M = 1'b0;
        as_A = '0;
        as_B = '0;
        if (state == ST_EXEC) begin
            case (op)
                OP_ADD: begin
                    as_A = opnd;
                    as_B = acc;
                end
                OP_SUB: begin
                    as_M = 1'b1;
                    as_A = opnd;
                    as_B = acc;
                end
                OP_MUL: begin
                    as_A = acc;
                    as_B = prod;
                end
                default: ;
            endcase
        end
    end

    accum_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .m   (as_M),
        .a   (as_A),
        .b   (as_B),
        .sum (as_Sum),
        .v   (fg_v),
        .z   (fg_z),
        .n   (fg_n)
    );

    assign out_acc = acc;
    assign out_c   = c_flag;
    assign out_v   = v_flag;
    assign out_z   = z_flag;
    assign out_n   = n_flag;

    // Control FSM: datapath registers and handshake outputs are all updated
    // here so in_ready/out_valid come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op        <= OP_LOAD;
            acc       <= '0;
            opnd      <= '0;
            prod      <= '0;
            cnt       <= '0;
            c_flag    <= 1'b0;
            v_flag    <= 1'b0;
            z_flag    <= 1'b0;
            n_flag    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op       <= req_op;
                        opnd     <= in_data;
                        in_ready <= 1'b0;
                        case (req_op)
                            OP_LOAD: begin
                                acc       <= in_data;
                                c_flag    <= 1'b0;
                                v_flag    <= 1'b0;
                                z_flag    <= (in_data == '0);
                                n_flag    <= in_data[WIDTH-1];
                                out_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                            OP_MUL: begin
                                if (in_data == '0) begin
                                    // Zero passes: product is 0 without touching the adder.
                                    acc       <= '0;
                                    c_flag    <= 1'b0;
                                    v_flag    <= 1'b0;
                                    z_flag    <= 1'b1;
                                    n_flag    <= 1'b0;
                                    out_valid <= 1'b1;
                                    state     <= ST_RESP;
                                end else begin
                                    prod   <= '0;
                                    cnt    <= in_data;
                                    c_flag <= 1'b0;
                                    state  <= ST_EXEC;
                                end
                            end
                            default: state <= ST_EXEC;
                        endcase
                    end
                end

                ST_EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            acc       <= as_Sum;
                            c_flag    <= as_C4;
                            v_flag    <= fg_v;
                            z_flag    <= fg_z;
                            n_flag    <= fg_n;
                            out_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                        OP_MUL: begin
                            // Any carry on any pass means the unsigned product wrapped.
                            prod   <= as_Sum;
                            cnt    <= cnt - 1'b1;
                            c_flag <= c_flag | as_C4;
                            if (cnt == WIDTH'(1)) begin
                                acc       <= as_Sum;
                                v_flag    <= 1'b0;
                                z_flag    <= fg_z;
                                n_flag    <= fg_n;
                                out_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                        end
                        default: begin
                            out_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    endcase
                end

                ST_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_accumulator_ctrl.sv
// Bench for addsub_accumulator_ctrl: models the external adder/subtractor,
// applies a directed vector table, random requests checked against an
// arithmetic reference, a stalled-response sequence and a reset abort.
module tb_addsub_accumulator_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_data;
    logic       as_M;
    logic [3:0] as_A;
    logic [3:0] as_B;
    logic [3:0] as_Sum;
    logic       as_C4;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_acc;
    logic       out_c, out_v, out_z, out_n;

    int n_total = 0;
    int n_pass  = 0;
    int m_acc   = 0;

    always #5 clk = ~clk;

    addsub_accumulator_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
        .as_M(as_M), .as_A(as_A), .as_B(as_B), .as_Sum(as_Sum), .as_C4(as_C4),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
    );

    // External 4-bit adder/subtractor: B+A, or B-A as B + ~A + 1.
    logic [4:0] as_full;
    always_comb begin
        as_full = as_M ? ({1'b0, as_B} + {1'b0, ~as_A} + 5'd1) : ({1'b0, as_B} + {1'b0, as_A});
        as_Sum  = as_full[3:0];
        as_C4   = as_full[4];
    end

    typedef struct {
        string name;
        int    op;
        int    data;
        int    acc, c, v, z, n, lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    // Reference: plain integer arithmetic on the current accumulator.
    task automatic model(input int op, input int d, input int a,
                         output int r, output int c, output int v, output int z,
                         output int n, output int lat);
        int sa, sd, s;
        sa = (a >= 8) ? a - 16 : a;
        sd = (d >= 8) ? d - 16 : d;
        c = 0; v = 0; r = 0; lat = 1;
        case (op)
            0: r = d;
            1: begin
                r = (a + d) % 16; c = (a + d > 15); s = sa + sd;
                v = (s > 7 || s < -8); lat = 2;
            end
            2: begin
                r = (a - d + 16) % 16; c = (a >= d); s = sa - sd;
                v = (s > 7 || s < -8); lat = 2;
            end
            default: begin
                r = (a * d) % 16; c = (a * d > 15); lat = 1 + d;
            end
        endcase
        z = (r == 0);
        n = (r >= 8);
    endtask

    task automatic wait_ready(input string nm);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, 0, 1);
    endtask

    // One full transaction: accept, latency measurement, result check, drain.
    task automatic run_req(input vec_t t);
        int k;
        wait_ready(t.name);
        in_valid = 1'b1; in_op = 2'(t.op); in_data = 4'(t.data);
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = 2'($urandom_range(0, 3)); in_data = 4'($urandom);
        if (t.lat > 1) begin
            chk({t.name, "_exec_M"}, 32'(as_M), (t.op == 2) ? 1 : 0);
            chk({t.name, "_exec_A"}, 32'(as_A), (t.op == 3) ? m_acc : t.data);
            chk({t.name, "_exec_B"}, 32'(as_B), (t.op == 3) ? 0 : m_acc);
        end
        k = 1;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1; k++;
        end
        chk({t.name, "_lat"}, k, t.lat);
        chk({t.name, "_acc"}, 32'(out_acc), t.acc);
        chk({t.name, "_cvzn"}, {28'd0, out_c, out_v, out_z, out_n},
            {28'd0, t.c[0], t.v[0], t.z[0], t.n[0]});
        chk({t.name, "_in_ready_busy"}, 32'(in_ready), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({t.name, "_drained"}, 32'(out_valid), 0);
        m_acc = t.acc;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t t;
        int   r, c, v, z, n, lat;

        // Directed vectors, expected values hand-derived.
        tbl.push_back('{"load5",   0, 5,  5, 0, 0, 0, 0, 1});
        tbl.push_back('{"add3",    1, 3,  8, 0, 1, 0, 1, 2});
        tbl.push_back('{"add8",    1, 8,  0, 1, 1, 1, 0, 2});
        tbl.push_back('{"load3",   0, 3,  3, 0, 0, 0, 0, 1});
        tbl.push_back('{"sub5",    2, 5, 14, 0, 0, 0, 1, 2});
        tbl.push_back('{"load5b",  0, 5,  5, 0, 0, 0, 0, 1});
        tbl.push_back('{"sub3",    2, 3,  2, 1, 0, 0, 0, 2});
        tbl.push_back('{"load3b",  0, 3,  3, 0, 0, 0, 0, 1});
        tbl.push_back('{"mul5",    3, 5, 15, 0, 0, 0, 1, 6});
        tbl.push_back('{"load3c",  0, 3,  3, 0, 0, 0, 0, 1});
        tbl.push_back('{"mul6",    3, 6,  2, 1, 0, 0, 0, 7});
        tbl.push_back('{"mul0",    3, 0,  0, 0, 0, 1, 0, 1});

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_acc", 32'(out_acc), 0);
        chk("rst_flags", {28'd0, out_c, out_v, out_z, out_n}, 0);
        chk("rst_as", {27'd0, as_M, as_A, as_B} , 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) run_req(tbl[i]);

        // Randomized requests against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            t.name = $sformatf("rnd%0d", i);
            t.op   = int'($urandom_range(0, 3));
            t.data = int'($urandom_range(0, 15));
            model(t.op, t.data, m_acc, r, c, v, z, n, lat);
            t.acc = r; t.c = c; t.v = v; t.z = z; t.n = n; t.lat = lat;
            run_req(t);
        end

        // Stalled response: result held, busy request ignored.
        wait_ready("stall");
        in_valid = 1'b1; in_op = 2'd0; in_data = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_valid%0d", i), 32'(out_valid), 1);
            chk($sformatf("stall_acc%0d", i), 32'(out_acc), 6);
            chk($sformatf("stall_flags%0d", i), {28'd0, out_c, out_v, out_z, out_n}, 0);
            chk($sformatf("stall_in_ready%0d", i), 32'(in_ready), 0);
            in_valid = (i == 1); in_op = 2'd1; in_data = 4'd1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_no_accept%0d", i), {30'd0, out_valid, in_ready}, 1);
            @(posedge clk); #1;
        end
        chk("stall_acc_after", 32'(out_acc), 6);
        m_acc = 6;

        // Reset abort in the third EXEC cycle of a MUL.
        t = '{"abort_load7", 0, 7, 7, 0, 0, 0, 0, 1};
        run_req(t);
        wait_ready("abort");
        in_valid = 1'b1; in_op = 2'd3; in_data = 4'd9;
        @(posedge clk); #1;      // EXEC cycle 1
        in_valid = 1'b0;
        @(posedge clk); #1;      // EXEC cycle 2
        @(posedge clk); #1;      // EXEC cycle 3
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_acc", 32'(out_acc), 0);
        chk("abort_as", {27'd0, as_M, as_A, as_B}, 0);
        m_acc = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("abort_quiet%0d", i), 32'(out_valid), 0);
            @(posedge clk); #1;
        end
        t = '{"post_abort_add2", 1, 2, 2, 0, 0, 0, 0, 2};
        run_req(t);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator_ctrl.md
# addsub_accumulator_ctrl

Sequencing stage that sits directly upstream of the 4-bit adder/subtractor and consumes its result. It accepts operation requests over a valid/ready handshake and drives the adder/subtractor's M, A and B inputs. It captures Sum/C4 into a 4-bit accumulator with status flags and returns the result over a second valid/ready handshake. Multiplication is done as repeated addition through the same adder, one pass per cycle.

## Interface
- WIDTH, 4, datapath width; must equal the adder/subtractor width (only 4 supported)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  2  operation: LOAD=0, ADD=1, SUB=2, MUL=3
- in_data  in  WIDTH  operand (LOAD value / addend / subtrahend / multiplier count)
- as_M  out  1  to adder/subtractor mode input (1 = subtract)
- as_A  out  WIDTH  to adder/subtractor A input; the subtrahend side
- as_B  out  WIDTH  to adder/subtractor B input
- as_Sum  in  WIDTH  from adder/subtractor: B+A when M=0, B−A when M=1
- as_C4  in  1  carry out; for SUB, 1 = no borrow
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_acc  out  WIDTH  accumulator value
- out_c, out_v, out_z, out_n  out  1 each  carry, signed overflow, zero, negative

## Operation
- Registers: acc, opnd (latched in_data), prod, cnt, op, flags.
- The FSM has three states:
  - IDLE: in_ready=1. On accept, latch op/in_data.
    - LOAD → RESP with acc=in_data, C=V=0.
    - ADD/SUB → EXEC.
    - MUL: if in_data=0 → RESP with acc=0, C=V=0. Otherwise set prod=0, cnt=in_data → EXEC.
  - EXEC: in_ready=0. The adder is combinational, so the result is captured at the end of the same cycle.
    - ADD: as_M=0, as_A=opnd, as_B=acc. Then acc<=as_Sum, C=as_C4, V=(A[3]==B[3])&&(Sum[3]!=B[3]), go to RESP.
    - SUB: as_M=1, as_A=opnd, as_B=acc. Then acc<=as_Sum (acc−opnd), C=as_C4, V=(A[3]!=B[3])&&(Sum[3]!=B[3]), go to RESP.
    - MUL: as_M=0, as_A=acc, as_B=prod. Then prod<=as_Sum, C|=as_C4 (sticky), cnt−1. When cnt reaches 0: acc<=final Sum, V=0, go to RESP.
  - RESP: out_valid=1. On out_ready, go to IDLE.
- Z = (acc==0) and N = acc[3]. Both are derived from the value written to acc.
- Outside EXEC: as_M=0, as_A=0, as_B=0.
- All arithmetic is modulo 2^WIDTH. MUL is an unsigned product mod 16, and C flags any unsigned wrap.
- The accumulator persists across requests; only rst clears it.

## Timing
- Reset values: acc=0, all flags 0, out_valid=0, state IDLE, in_ready=1, as_M/as_A/as_B=0.
- Latency from the accept edge t:
  - LOAD and MUL-by-0: out_valid from cycle t+1.
  - ADD/SUB: out_valid from t+2.
  - MUL n: n EXEC cycles, out_valid from t+1+n.
- in_ready is high only in IDLE. Requests presented while busy are ignored (not accepted), and no accept coincides with a response.
- Once out_valid is high, out_acc and the flags are held stable until the handshake completes. A stalled out_ready holds the FSM in RESP indefinitely.
- in_op, in_data and out_ready are sampled only in their handshake cycles.
- rst during EXEC or RESP aborts the operation. In the next cycle the block is in the reset state and no result is emitted.

## Structure
- Shared package addsub_pkg holds: WIDTH localparam (4), op encoding OP_LOAD/OP_ADD/OP_SUB/OP_MUL, and state encoding ST_IDLE/ST_EXEC/ST_RESP.
- One sub-module: accum_flag_gen. It is combinational and computes V, Z and N from as_A, as_B, as_Sum and as_M.
- The adder/subtractor itself is instantiated at the level above this block, not inside it.

## Test plan
- Reset, then LOAD 5 → out_valid at accept+1; out_acc=5, C=V=Z=N=0.
- ADD path:
  - acc=5, ADD 3 → out_valid at accept+2; out_acc=8, N=1, V=1, C=0.
  - Then ADD 8 → out_acc=0, C=1, Z=1, V=1.
- SUB path:
  - acc=3, SUB 5 → out_acc=14, C=0, N=1, V=0.
  - acc=5, SUB 3 → out_acc=2, C=1.
- MUL path:
  - acc=3, MUL 5 → five EXEC cycles, out_valid at accept+6, out_acc=15, C=0.
  - acc=3, MUL 6 → out_acc=2, C=1.
  - MUL 0 → out_acc=0, Z=1 at accept+1.
- out_ready low for 4 cycles during RESP → out_valid, out_acc and flags stable, in_ready=0. A concurrent in_valid pulse is not accepted.
- acc=7, MUL 9, rst asserted in the 3rd EXEC cycle → next cycle out_valid=0, in_ready=1, out_acc=0, as_M/as_A/as_B=0.
